ddfs_core: RTL and testbench

Direct digital frequency synthesis engine that drives the 16-bit sine lookup ROM. It is the read-side master of the ROM port.
- Keeps a phase accumulator and issues ROM addresses from it.
- Captures the registered ROM data one clock later.
- Scales that data by a signed amplitude envelope and presents a saturated PCM sample with a valid strobe.
- Also outputs a square wave taken from the phase MSB.
- Sits between the control/register layer (tuning words, envelope, sample tick) and the DAC/PWM back end.

---
 rtl/ddfs_core.sv | 78 +++++++
 tb/tb_ddfs_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_core.sv
// Direct digital frequency synthesiser: phase accumulator driving a registered sine ROM,
// followed by a signed Q2.14 envelope multiply with saturation and a square-wave output.
module ddfs_core #(
  parameter int PW         = 30,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  phase_clr,
  input  logic [PW-1:0]         fccw,
  input  logic [PW-1:0]         focw,
  input  logic [PW-1:0]         pha,
  input  logic [DATA_WIDTH-1:0] env,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] pcm_out,
  output logic                  pcm_valid,
  output logic                  pulse_out
);

  localparam int PWIDE = 2 * DATA_WIDTH;
  localparam int FRAC  = DATA_WIDTH - 2;
  localparam logic signed [PWIDE-1:0] SAT_MAX = PWIDE'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [PWIDE-1:0] SAT_MIN = -SAT_MAX - PWIDE'(1);

  logic [PW-1:0]           phase_reg;
  logic [PW-1:0]           base;
  logic                    v1;
  logic                    v2;
  logic signed [PWIDE-1:0] scaled;
  logic [DATA_WIDTH-1:0]   sat;

  assign base      = phase_clr ? '0 : phase_reg;
  assign pulse_out = phase_reg[PW-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= '0;
      rom_addr  <= '0;
      v1        <= 1'b0;
    end else if (en) begin
      phase_reg <= base + fccw + focw;
      rom_addr  <= ADDR_WIDTH'((base + pha) >> (PW - ADDR_WIDTH));
      v1        <= 1'b1;
    end else begin
      v1 <= 1'b0;
      if (phase_clr)
        phase_reg <= '0;
    end
  end

  // Full-width signed product; arithmetic shift floors toward minus infinity.
  assign scaled = (PWIDE'($signed(rom_data)) * PWIDE'($signed(env))) >>> FRAC;

  always_comb begin
    sat = scaled[DATA_WIDTH-1:0];
    if (scaled > SAT_MAX)
      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (scaled < SAT_MIN)
      sat = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v2        <= 1'b0;
      pcm_valid <= 1'b0;
      pcm_out   <= '0;
    end else begin
      v2        <= v1;
      pcm_valid <= v2;
      if (v2)
        pcm_out <= sat;
    end
  end

endmodule

// File: tb/tb_ddfs_core.sv
// Bench for ddfs_core: a behavioural ROM plus a scoreboard queue of expected samples,
// popped when pcm_valid is due two clocks after each launch.
module tb_ddfs_core;
  localparam int PW = 30;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          phase_clr = 1'b0;
  logic [PW-1:0] fccw = '0;
  logic [PW-1:0] focw = '0;
  logic [PW-1:0] pha = '0;
  logic [DW-1:0] env = 16'h4000;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] pcm_out;
  logic          pcm_valid;
  logic          pulse_out;

  logic [DW-1:0] rom [256];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          mon_en = 1'b0;
  logic          exp_v;
  logic [PW-1:0] ph = '0;
  logic [AW-1:0] ea;

  typedef struct {
    int            due;
    logic [DW-1:0] pcm;
  } sb_t;
  sb_t sbq[$];

  ddfs_core #(.PW(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .en(en), .phase_clr(phase_clr),
    .fccw(fccw), .focw(focw), .pha(pha), .env(env),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid), .pulse_out(pulse_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr];
  end

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] r, input logic [DW-1:0] e);
    longint p;
    p = longint'($signed(r)) * longint'($signed(e));
    p = p >>> 14;
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  // Scoreboard consumer: pcm_valid must be high exactly when the head entry is due.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
      total++;
      if (pcm_valid !== exp_v) begin
        bad++;
        $display("FAIL pcm_valid cyc=%0d got=%b exp=%b", cyc, pcm_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (pcm_out !== sbq[0].pcm) begin
          bad++;
          $display("FAIL pcm_out cyc=%0d got=%h exp=%h", cyc, pcm_out, sbq[0].pcm);
        end
        void'(sbq.pop_front());
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        void'(sbq.pop_front());
      end
    end
  end

  // One clock: drive inputs, advance the reference phase, queue the expected sample.
  task automatic step(input logic e, input logic c, output logic [AW-1:0] exp_addr);
    logic [PW-1:0] b;
    sb_t item;
    en = e;
    phase_clr = c;
    b = c ? '0 : ph;
    exp_addr = AW'((b + pha) >> (PW - AW));
    @(posedge clk);
    #1;
    if (e) begin
      ph = b + fccw + focw;
      item.due = cyc + 2;
      item.pcm = scale(rom[exp_addr], env);
      sbq.push_back(item);
    end else if (c) begin
      ph = '0;
    end
    en = 1'b0;
    phase_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    phase_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sbq.delete();
    ph = '0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", rom_addr); end
    total++; if (pcm_out !== 16'h0000) begin bad++; $display("FAIL reset_pcm got=%h exp=0000", pcm_out); end
    total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pcm_valid); end
    total++; if (pulse_out !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", pulse_out); end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_sweep();
    logic [AW-1:0] exp_a;
    do_reset();
    fccw = 30'h0040_0000; focw = '0; pha = '0; env = 16'h4000;
    for (int i = 0; i < 258; i++) begin
      step(1'b1, 1'b0, ea);
      exp_a = i[7:0];
      total++;
      if (rom_addr !== exp_a) begin bad++; $display("FAIL sweep_addr i=%0d got=%0d exp=%0d", i, rom_addr, exp_a); end
    end
    repeat (3) step(1'b0, 1'b0, ea);
  endtask

  task automatic test_phase_offset();
    logic [AW-1:0] exp_a;
    logic          exp_p;
    int            j;
    do_reset();
    fccw = 30'h0040_0000; focw = '0; pha = 30'h1000_0000; env = 16'h4000;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b0, ea);
      j = 64 + i;
      exp_a = j[7:0];
      j = ((i + 1) >> 7) & 1;
      exp_p = j[0];
      total++;
      if (rom_addr !== exp_a) begin bad++; $display("FAIL offset_addr i=%0d got=%0d exp=%0d", i, rom_addr, exp_a); end
      total++;
      if (pulse_out !== exp_p) begin bad++; $display("FAIL offset_pulse i=%0d got=%b exp=%b", i, pulse_out, exp_p); end
    end
    repeat (3) step(1'b0, 1'b0, ea);
    pha = '0;
  endtask

  typedef struct {
    int            addr;
    logic [DW-1:0] e;
    logic [DW-1:0] exp;
  } sat_t;

  task automatic test_saturation();
    sat_t tbl [6];
    tbl[0] = '{10, 16'h7FFF, 16'h7FFF};
    tbl[1] = '{11, 16'h7FFF, 16'h8000};
    tbl[2] = '{10, 16'h2000, 16'h3FFF};
    tbl[3] = '{11, 16'hC000, 16'h7FFF};
    tbl[4] = '{12, 16'hC000, 16'hEDCC};
    tbl[5] = '{13, 16'h2000, 16'hFFFF};
    do_reset();
    fccw = '0; focw = '0;
    for (int i = 0; i < 6; i++) begin
      pha = PW'(tbl[i].addr) << (PW - AW);
      env = tbl[i].e;
      step(1'b1, 1'b1, ea);
      repeat (3) step(1'b0, 1'b0, ea);
      total++;
      if (pcm_out !== tbl[i].exp) begin bad++; $display("FAIL sat_%0d got=%h exp=%h", i, pcm_out, tbl[i].exp); end
    end
    pha = '0;
    env = 16'h4000;
  endtask

  task automatic test_gated_fm();
    logic [AW-1:0] exp_a;
    int            h;
    do_reset();
    fccw = 30'h0040_0000; focw = 30'h3FE0_0000; pha = '0; env = 16'h4000;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, ea);
      h = k >> 1;
      exp_a = h[7:0];
      total++;
      if (rom_addr !== exp_a) begin bad++; $display("FAIL fm_addr k=%0d got=%0d exp=%0d", k, rom_addr, exp_a); end
      repeat (3) step(1'b0, 1'b0, ea);
      total++;
      if (rom_addr !== exp_a) begin bad++; $display("FAIL fm_hold k=%0d got=%0d exp=%0d", k, rom_addr, exp_a); end
    end
    focw = '0;
  endtask

  task automatic test_phase_clr();
    do_reset();
    focw = '0; pha = '0; env = 16'h4000;
    fccw = 30'h2345_6789;
    step(1'b1, 1'b0, ea);
    total++; if (pulse_out !== 1'b1) begin bad++; $display("FAIL clr_pre_pulse got=%b exp=1", pulse_out); end
    fccw = 30'h01C0_0000;
    step(1'b1, 1'b1, ea);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL clr_addr got=%h exp=00", rom_addr); end
    total++; if (dut.phase_reg !== 30'h01C0_0000) begin bad++; $display("FAIL clr_phase got=%h exp=01c00000", dut.phase_reg); end
    total++; if (pulse_out !== 1'b0) begin bad++; $display("FAIL clr_pulse got=%b exp=0", pulse_out); end
    fccw = '0;
    step(1'b1, 1'b0, ea);
    total++; if (rom_addr !== 8'h07) begin bad++; $display("FAIL clr_next_addr got=%h exp=07", rom_addr); end
    step(1'b0, 1'b1, ea);
    total++; if (rom_addr !== 8'h07) begin bad++; $display("FAIL clr_idle_hold got=%h exp=07", rom_addr); end
    step(1'b1, 1'b0, ea);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL clr_idle_addr got=%h exp=00", rom_addr); end
    repeat (3) step(1'b0, 1'b0, ea);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    fccw = 30'h0040_0000; focw = '0; pha = '0; env = 16'h4000;
    repeat (5) step(1'b1, 1'b0, ea);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    ph = '0;
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL mid_addr got=%h exp=00", rom_addr); end
    total++; if (pcm_out !== 16'h0000) begin bad++; $display("FAIL mid_pcm got=%h exp=0000", pcm_out); end
    total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", pcm_valid); end
    total++; if (pulse_out !== 1'b0) begin bad++; $display("FAIL mid_pulse got=%b exp=0", pulse_out); end
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0, ea);
    step(1'b1, 1'b0, ea);
    total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL mid_first_addr got=%h exp=00", rom_addr); end
    repeat (3) step(1'b0, 1'b0, ea);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[10] = 16'h7FFF;
    rom[11] = 16'h8000;
    rom[12] = 16'h1234;
    rom[13] = 16'hFFFF;
    test_reset();
    test_sweep();
    test_phase_offset();
    test_saturation();
    test_gated_fm();
    test_phase_clr();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
